interp_ram_reader: RTL and testbench

- Read-side engine for the interpolation sample RAM: 32-bit words, 1024 deep, simple dual-port, read latency 1, no output register.
- Walks a fixed-point phase accumulator across the stored table.
- For each step it fetches the two neighbouring samples and emits their linear interpolation on a valid/ready stream.
- Sits between the RAM read port and downstream DSP. The RAM write side is owned by the sample loader.

---
 rtl/interp_ram_reader_pkg.sv | 9 +
 rtl/interp_ram_reader_if.sv | 29 ++
 rtl/interp_ram_reader_lerp.sv | 18 +
 rtl/interp_ram_reader.sv | 75 +++++++
 tb/tb_interp_ram_reader.sv | 173 +++++++++++++++++
 5 files changed

// File: rtl/interp_ram_reader_pkg.sv
// interp_pkg: shared widths and FSM states for the interpolating RAM reader
package interp_pkg;
  localparam int ADDR_W = 10;
  localparam int DATA_W = 32;
  localparam int FRAC_W = 8;
  localparam int CNT_W = 16;
  localparam int PHASE_W = ADDR_W + FRAC_W;
  typedef enum logic [2:0] {IDLE, RD_A, RD_B, CALC, OUT, DONE} state_e;
endpackage

// File: rtl/interp_ram_reader_if.sv
// interp_ram_reader_if: command, RAM read port and output stream of the reader
interface interp_ram_reader_if
  import interp_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_W,
  parameter int DATA_WIDTH = DATA_W,
  parameter int FRAC_WIDTH = FRAC_W,
  parameter int CNT_WIDTH = CNT_W
);
  logic start;
  logic [ADDR_WIDTH+FRAC_WIDTH-1:0] start_phase;
  logic [ADDR_WIDTH+FRAC_WIDTH-1:0] step;
  logic [CNT_WIDTH-1:0] num_out;
  logic [ADDR_WIDTH-1:0] ram_rd_addr;
  logic [DATA_WIDTH-1:0] ram_rd_data;
  logic [DATA_WIDTH-1:0] out_data;
  logic out_valid;
  logic out_ready;
  logic busy;
  logic done;
  modport master (
    input start, start_phase, step, num_out, ram_rd_data, out_ready,
    output ram_rd_addr, out_data, out_valid, busy, done
  );
  modport slave (
    output start, start_phase, step, num_out, ram_rd_data, out_ready,
    input ram_rd_addr, out_data, out_valid, busy, done
  );
endinterface

// File: rtl/interp_ram_reader_lerp.sv
// interp_lerp: y = a + floor((b - a) * frac / 2**FRAC_WIDTH), signed samples
module interp_lerp #(
  parameter int DATA_WIDTH = 32,
  parameter int FRAC_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic [FRAC_WIDTH-1:0] frac,
  output logic [DATA_WIDTH-1:0] y
);
  localparam int PW = DATA_WIDTH + FRAC_WIDTH + 2;
  logic signed [DATA_WIDTH:0] w_diff;
  logic signed [PW-1:0] w_prod;
  assign w_diff = $signed({b[DATA_WIDTH-1], b}) - $signed({a[DATA_WIDTH-1], a});
  assign w_prod = PW'(w_diff) * PW'($signed({1'b0, frac}));
  // result lies between a and b, so truncation cannot overflow
  assign y = a + DATA_WIDTH'(w_prod >>> FRAC_WIDTH);
endmodule

// File: rtl/interp_ram_reader.sv
// interp_ram_reader: walks a phase accumulator over the sample RAM, streams lerped samples
module interp_ram_reader
  import interp_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_W,
  parameter int DATA_WIDTH = DATA_W,
  parameter int FRAC_WIDTH = FRAC_W,
  parameter int CNT_WIDTH = CNT_W
) (
  input logic rd_clk,
  input logic rd_rst,
  interp_ram_reader_if.master bus
);
  localparam int PW = ADDR_WIDTH + FRAC_WIDTH;
  state_e r_state;
  logic [PW-1:0] r_phase;
  logic [PW-1:0] r_step;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic [DATA_WIDTH-1:0] r_a;
  logic [DATA_WIDTH-1:0] r_out_data;
  logic [DATA_WIDTH-1:0] w_y;
  logic [ADDR_WIDTH-1:0] w_idx;
  logic w_fire;
  assign w_idx = r_phase[PW-1:FRAC_WIDTH];
  assign w_fire = (r_state == OUT) && bus.out_ready;
  // the neighbour read wraps so the last entry pairs with entry 0
  assign bus.ram_rd_addr = (r_state == RD_B) ? w_idx + ADDR_WIDTH'(1) : w_idx;
  assign bus.out_data = r_out_data;
  assign bus.out_valid = r_state == OUT;
  assign bus.busy = r_state != IDLE;
  assign bus.done = r_state == DONE;
  interp_lerp #(
    .DATA_WIDTH(DATA_WIDTH),
    .FRAC_WIDTH(FRAC_WIDTH)
  ) u_lerp (
    .a(r_a),
    .b(bus.ram_rd_data),
    .frac(r_phase[FRAC_WIDTH-1:0]),
    .y(w_y)
  );
  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      r_state <= IDLE;
      r_phase <= '0;
      r_step <= '0;
      r_cnt <= '0;
      r_a <= '0;
      r_out_data <= '0;
    end else begin
      case (r_state)
        IDLE: if (bus.start) begin
          r_phase <= bus.start_phase;
          r_step <= bus.step;
          r_cnt <= bus.num_out;
          r_state <= (bus.num_out == '0) ? DONE : RD_A;
        end
        RD_A: r_state <= RD_B;
        RD_B: begin
          r_a <= bus.ram_rd_data;
          r_state <= CALC;
        end
        CALC: begin
          r_out_data <= w_y;
          r_state <= OUT;
        end
        OUT: if (w_fire) begin
          r_phase <= r_phase + r_step;
          r_cnt <= r_cnt - CNT_WIDTH'(1);
          r_state <= (r_cnt == CNT_WIDTH'(1)) ? DONE : RD_A;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_interp_ram_reader.sv
// tb_interp_ram_reader: directed vectors plus corner sequences against a 1-cycle RAM model
module tb_interp_ram_reader;
  logic rd_clk = 0;
  logic rd_rst;
  int checks = 0;
  int failures = 0;
  logic [31:0] ram [1024];
  typedef struct {
    logic [17:0] sp;
    logic [17:0] st;
    logic [15:0] n;
    logic [3:0][31:0] exp;
  } vec_t;
  vec_t vecs [5];
  interp_ram_reader_if bus_if ();
  interp_ram_reader dut (.rd_clk(rd_clk), .rd_rst(rd_rst), .bus(bus_if.master));
  always #5 rd_clk = ~rd_clk;
  always @(posedge rd_clk) bus_if.ram_rd_data <= ram[bus_if.ram_rd_addr];
  task automatic tick();
    @(posedge rd_clk);
    #1;
  endtask
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h)", name, act, act, exp, exp);
    end
  endtask
  task automatic go(input logic [17:0] sp, input logic [17:0] st, input logic [15:0] n);
    bus_if.start = 1;
    bus_if.start_phase = sp;
    bus_if.step = st;
    bus_if.num_out = n;
    tick();
    bus_if.start = 0;
  endtask
  task automatic run_vec(input vec_t v);
    int lat;
    go(v.sp, v.st, v.n);
    for (int k = 0; k < int'(v.n); k++) begin
      lat = 0;
      while (!bus_if.out_valid && lat < 20) begin
        tick();
        lat++;
      end
      check("latency", lat, 3);
      check("out_data", bus_if.out_data, v.exp[k]);
      tick();
      check("valid_fall", 32'(bus_if.out_valid), 0);
      check("done_after_hs", 32'(bus_if.done), (k == int'(v.n) - 1) ? 1 : 0);
    end
    tick();
    check("done_clear", 32'(bus_if.done), 0);
    check("busy_clear", 32'(bus_if.busy), 0);
  endtask
  initial begin
    int nv, nd, lat;
    logic [9:0] addr;
    for (int k = 0; k < 1024; k++) ram[k] = k * 256;
    ram[1023] = 1000;
    ram[5] = 100;
    ram[6] = 32'hFFFF_FF9C;
    vecs[0] = '{sp: 18'h00000, st: 18'h080, n: 4, exp: {32'd384, 32'd256, 32'd128, 32'd0}};
    vecs[1] = '{sp: 18'h3FF80, st: 18'h100, n: 2, exp: {32'd0, 32'd0, 32'd128, 32'd500}};
    vecs[2] = '{sp: 18'h00540, st: 18'h100, n: 1, exp: {32'd0, 32'd0, 32'd0, 32'h32}};
    vecs[3] = '{sp: 18'h00300, st: 18'h100, n: 2, exp: {32'd0, 32'd0, 32'd1024, 32'd768}};
    vecs[4] = '{sp: 18'h00100, st: 18'h0C0, n: 3, exp: {32'd0, 32'd640, 32'd448, 32'd256}};
    bus_if.start = 0;
    bus_if.start_phase = 0;
    bus_if.step = 0;
    bus_if.num_out = 0;
    bus_if.out_ready = 1;
    rd_rst = 1;
    tick();
    tick();
    rd_rst = 0;
    check("rst_valid", 32'(bus_if.out_valid), 0);
    check("rst_done", 32'(bus_if.done), 0);
    check("rst_busy", 32'(bus_if.busy), 0);
    check("rst_data", bus_if.out_data, 0);
    check("rst_addr", 32'(bus_if.ram_rd_addr), 0);
    for (int i = 0; i < 5; i++) run_vec(vecs[i]);
    go(18'h3FF80, 18'h100, 2);
    check("wrap_addr0", 32'(bus_if.ram_rd_addr), 1023);
    tick();
    check("wrap_addr1", 32'(bus_if.ram_rd_addr), 0);
    tick();
    tick();
    check("wrap_y0", bus_if.out_data, 500);
    tick();
    check("wrap_addr2", 32'(bus_if.ram_rd_addr), 0);
    tick();
    check("wrap_addr3", 32'(bus_if.ram_rd_addr), 1);
    tick();
    tick();
    check("wrap_y1", bus_if.out_data, 128);
    tick();
    tick();
    bus_if.out_ready = 0;
    go(18'h00000, 18'h080, 4);
    tick();
    tick();
    tick();
    addr = bus_if.ram_rd_addr;
    for (int c = 0; c < 10; c++) begin
      check("bp_valid", 32'(bus_if.out_valid), 1);
      check("bp_data", bus_if.out_data, 0);
      check("bp_addr", 32'(bus_if.ram_rd_addr), 32'(addr));
      tick();
    end
    bus_if.out_ready = 1;
    tick();
    check("bp_valid_fall", 32'(bus_if.out_valid), 0);
    for (int k = 1; k < 4; k++) begin
      tick();
      tick();
      tick();
      check("bp_valid_k", 32'(bus_if.out_valid), 1);
      check("bp_data_k", bus_if.out_data, vecs[0].exp[k]);
      tick();
    end
    check("bp_done", 32'(bus_if.done), 1);
    tick();
    go(18'h00000, 18'h080, 0);
    check("zero_done", 32'(bus_if.done), 1);
    check("zero_valid", 32'(bus_if.out_valid), 0);
    tick();
    check("zero_done_fall", 32'(bus_if.done), 0);
    check("zero_busy", 32'(bus_if.busy), 0);
    go(18'h00000, 18'h080, 4);
    tick();
    bus_if.start = 1;
    bus_if.start_phase = 18'h00540;
    bus_if.num_out = 1;
    tick();
    bus_if.start = 0;
    nv = 0;
    nd = 0;
    for (int c = 0; c < 40; c++) begin
      if (bus_if.out_valid) begin
        if (nv < 4) check("ign_data", bus_if.out_data, vecs[0].exp[nv]);
        nv++;
      end
      if (bus_if.done) nd++;
      tick();
    end
    check("ign_count", nv, 4);
    check("ign_done_count", nd, 1);
    go(18'h00000, 18'h080, 4);
    tick();
    tick();
    tick();
    tick();
    tick();
    check("mid_rdb_addr", 32'(bus_if.ram_rd_addr), 1);
    rd_rst = 1;
    tick();
    rd_rst = 0;
    check("mid_busy", 32'(bus_if.busy), 0);
    check("mid_valid", 32'(bus_if.out_valid), 0);
    check("mid_done", 32'(bus_if.done), 0);
    lat = 0;
    for (int c = 0; c < 5; c++) begin
      if (bus_if.done || bus_if.busy) lat++;
      tick();
    end
    check("mid_quiet", lat, 0);
    run_vec(vecs[0]);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
